// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared core-control types for the pipeline stall/flush sequencer.
package pipeline_stall_ctrl_pkg;

  localparam int unsigned TimeoutCyclesDefault = 255;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_BUBBLE   = 2'd1,
    ST_MEM_WAIT = 2'd2
  } stall_state_e;

  typedef struct packed {
    logic pc_stall;
    logic if_id_stall;
    logic if_id_flush;
    logic id_ex_nop;
    logic ex_mem_stall;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CtrlIdle = '{
    pc_stall: 1'b0, if_id_stall: 1'b0, if_id_flush: 1'b0, id_ex_nop: 1'b0, ex_mem_stall: 1'b0
  };
  localparam pipe_ctrl_t CtrlMemStall = '{
    pc_stall: 1'b1, if_id_stall: 1'b1, if_id_flush: 1'b0, id_ex_nop: 1'b0, ex_mem_stall: 1'b1
  };
  localparam pipe_ctrl_t CtrlFlush = '{
    pc_stall: 1'b0, if_id_stall: 1'b0, if_id_flush: 1'b1, id_ex_nop: 1'b1, ex_mem_stall: 1'b0
  };
  localparam pipe_ctrl_t CtrlLoadBubble = '{
    pc_stall: 1'b1, if_id_stall: 1'b1, if_id_flush: 1'b0, id_ex_nop: 1'b1, ex_mem_stall: 1'b0
  };

endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating up-counter with increment enable and asynchronous active-high reset.
module sat_counter #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != {Width{1'b1}})) begin
      count_d = count_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall/flush sequencer: merges load-use, branch redirect and dmem handshake.
// Performance counters are built only when STALL_PERF_CNT_EN is defined.
module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TimeoutCyclesDefault,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic load_hazzard,
  input  logic branch_taken,
  input  logic dmem_req,
  input  logic dmem_ready,
  output logic pc_stall,
  output logic if_id_stall,
  output logic if_id_flush,
  output logic id_ex_nop,
  output logic ex_mem_stall,
  output logic mem_timeout
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] load_bubble_cnt,
  output logic [CNT_WIDTH-1:0] mem_wait_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt
`endif
);

  localparam int unsigned WaitW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WaitW-1:0] WaitMax = WaitW'(TIMEOUT_CYCLES);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535 || CNT_WIDTH < 1) begin : g_param_check
    $error("pipeline_stall_ctrl: parameter out of range");
  end

  stall_state_e     state_q, state_d;
  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
  logic             timeout_q, timeout_d;
  logic             mem_freeze;
  pipe_ctrl_t       ctrl;

  // Dropping dmem_req without ready ends a wait just like ready does.
  assign mem_freeze = dmem_req & ~dmem_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      ST_RUN, ST_BUBBLE: begin
        if (mem_freeze) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = WaitW'(1);
        end else if (branch_taken) begin
          state_d = ST_RUN;
        end else if ((state_q == ST_RUN) && load_hazzard) begin
          state_d = ST_BUBBLE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_freeze) begin
          if (wait_cnt_q != WaitMax) begin
            wait_cnt_d = wait_cnt_q + WaitW'(1);
          end
        end else begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
      end
    endcase
    timeout_d = timeout_q | ((state_d == ST_MEM_WAIT) && (wait_cnt_d == WaitMax));
  end

  // Controls are forced idle while reset is held so the pipeline sees no stray stall.
  always_comb begin
    ctrl = CtrlIdle;
    if (!rst) begin
      unique case (state_q)
        ST_RUN, ST_BUBBLE: begin
          if (mem_freeze) begin
            ctrl = CtrlMemStall;
          end else if (branch_taken) begin
            ctrl = CtrlFlush;
          end else if ((state_q == ST_RUN) && load_hazzard) begin
            ctrl = CtrlLoadBubble;
          end
        end
        ST_MEM_WAIT: begin
          if (mem_freeze) begin
            ctrl = CtrlMemStall;
          end
        end
        default: ctrl = CtrlIdle;
      endcase
    end
  end

  assign pc_stall     = ctrl.pc_stall;
  assign if_id_stall  = ctrl.if_id_stall;
  assign if_id_flush  = ctrl.if_id_flush;
  assign id_ex_nop    = ctrl.id_ex_nop;
  assign ex_mem_stall = ctrl.ex_mem_stall;
  assign mem_timeout  = timeout_q;

`ifdef STALL_PERF_CNT_EN
  sat_counter #(
    .Width(CNT_WIDTH)
  ) u_load_bubble_cnt (
    .clk_i  (clk),
    .rst_i  (rst),
    .inc_i  (ctrl.pc_stall & ctrl.id_ex_nop),
    .count_o(load_bubble_cnt)
  );

  sat_counter #(
    .Width(CNT_WIDTH)
  ) u_mem_wait_cnt (
    .clk_i  (clk),
    .rst_i  (rst),
    .inc_i  (ctrl.ex_mem_stall),
    .count_o(mem_wait_cnt)
  );

  sat_counter #(
    .Width(CNT_WIDTH)
  ) u_flush_cnt (
    .clk_i  (clk),
    .rst_i  (rst),
    .inc_i  (ctrl.if_id_flush),
    .count_o(flush_cnt)
  );
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Randomized self-checking bench for pipeline_stall_ctrl against a rule-level model.
module tb_pipeline_stall_ctrl;

  localparam int unsigned TbTimeout = 4;
  localparam int unsigned TbCntW    = 6;
  localparam int          CntSat    = (1 << TbCntW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic load_hazzard = 1'b0;
  logic branch_taken = 1'b0;
  logic dmem_req = 1'b0;
  logic dmem_ready = 1'b0;
  logic pc_stall, if_id_stall, if_id_flush, id_ex_nop, ex_mem_stall, mem_timeout;
`ifdef STALL_PERF_CNT_EN
  logic [TbCntW-1:0] load_bubble_cnt, mem_wait_cnt, flush_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Model: "are we inside a memory wait", "was last cycle a load bubble", wait length.
  bit m_in_wait, m_after_bubble, m_timeout;
  int m_wait_len;
  int m_lb, m_mw, m_fl;

  pipeline_stall_ctrl #(
    .TIMEOUT_CYCLES(TbTimeout),
    .CNT_WIDTH     (TbCntW)
  ) u_dut (
    .clk            (clk),
    .rst            (rst),
    .load_hazzard   (load_hazzard),
    .branch_taken   (branch_taken),
    .dmem_req       (dmem_req),
    .dmem_ready     (dmem_ready),
    .pc_stall       (pc_stall),
    .if_id_stall    (if_id_stall),
    .if_id_flush    (if_id_flush),
    .id_ex_nop      (id_ex_nop),
    .ex_mem_stall   (ex_mem_stall),
    .mem_timeout    (mem_timeout)
`ifdef STALL_PERF_CNT_EN
    ,
    .load_bubble_cnt(load_bubble_cnt),
    .mem_wait_cnt   (mem_wait_cnt),
    .flush_cnt      (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_in_wait      = 1'b0;
    m_after_bubble = 1'b0;
    m_timeout      = 1'b0;
    m_wait_len     = 0;
    m_lb = 0;
    m_mw = 0;
    m_fl = 0;
  endtask

  task automatic check_regs();
    check_eq("mem_timeout", 32'(mem_timeout), 32'(m_timeout));
`ifdef STALL_PERF_CNT_EN
    check_eq("load_bubble_cnt", 32'(load_bubble_cnt), 32'(m_lb));
    check_eq("mem_wait_cnt", 32'(mem_wait_cnt), 32'(m_mw));
    check_eq("flush_cnt", 32'(flush_cnt), 32'(m_fl));
`endif
  endtask

  task automatic check_ctrl(input logic [4:0] e);
    check_eq("pc_stall", 32'(pc_stall), 32'(e[4]));
    check_eq("if_id_stall", 32'(if_id_stall), 32'(e[3]));
    check_eq("if_id_flush", 32'(if_id_flush), 32'(e[2]));
    check_eq("id_ex_nop", 32'(id_ex_nop), 32'(e[1]));
    check_eq("ex_mem_stall", 32'(ex_mem_stall), 32'(e[0]));
  endtask

  // One clock cycle: drive, check combinational controls and registered state, advance model.
  task automatic cycle(input bit req, input bit rdy, input bit br, input bit ld);
    logic [4:0] e;
    bit freeze;
    @(negedge clk);
    dmem_req     = req;
    dmem_ready   = rdy;
    branch_taken = br;
    load_hazzard = ld;
    #2;
    freeze = req && !rdy;
    if (freeze) e = 5'b11001;
    else if (m_in_wait) e = 5'b00000;
    else if (br) e = 5'b00110;
    else if (ld && !m_after_bubble) e = 5'b11010;
    else e = 5'b00000;
    check_ctrl(e);
    check_regs();
    if (freeze) begin
      m_wait_len     = m_in_wait ? ((m_wait_len < TbTimeout) ? m_wait_len + 1 : m_wait_len) : 1;
      m_in_wait      = 1'b1;
      m_after_bubble = 1'b0;
      if (m_wait_len == TbTimeout) m_timeout = 1'b1;
    end else if (m_in_wait) begin
      m_in_wait      = 1'b0;
      m_wait_len     = 0;
      m_after_bubble = 1'b0;
    end else begin
      m_after_bubble = !br && ld && !m_after_bubble;
    end
    if (e[4] && e[1] && m_lb < CntSat) m_lb++;
    if (e[0] && m_mw < CntSat) m_mw++;
    if (e[2] && m_fl < CntSat) m_fl++;
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst          = 1'b1;
    dmem_req     = 1'($urandom);
    dmem_ready   = 1'($urandom);
    branch_taken = 1'($urandom);
    load_hazzard = 1'($urandom);
    #1;
    model_reset();
    check_ctrl(5'b00000);
    check_regs();
    @(posedge clk);
    @(negedge clk);
    rst          = 1'b0;
    dmem_req     = 1'b0;
    dmem_ready   = 1'b0;
    branch_taken = 1'b0;
    load_hazzard = 1'b0;
    #1;
    check_ctrl(5'b00000);
    check_regs();
  endtask

  initial begin
    model_reset();
    do_reset();

    // Load-use held two cycles: one bubble, then masked.
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 0);

    // Memory wait with ready on the 4th cycle; then same-cycle req+ready.
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(1, 1, 0, 0);
    cycle(1, 1, 0, 0);
    cycle(0, 0, 0, 0);

    // Simultaneous events: freeze only, then branch flush after release.
    cycle(1, 0, 1, 1);
    cycle(1, 1, 1, 1);
    cycle(0, 0, 1, 1);
    cycle(0, 0, 0, 0);

    // Timeout: 4 wait cycles, flag sticky after ready.
    do_reset();
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    check_eq("timeout_early", 32'(mem_timeout), 32'd0);
    cycle(1, 0, 0, 0);
    cycle(1, 1, 0, 0);
    check_eq("timeout_sticky", 32'(mem_timeout), 32'd1);
    cycle(0, 0, 0, 0);

    // Asynchronous reset in the 2nd wait cycle, then count restarts from 1.
    do_reset();
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    @(negedge clk);
    dmem_req   = 1'b1;
    dmem_ready = 1'b0;
    #2;
    check_eq("mid_wait_stall", 32'(ex_mem_stall), 32'd1);
    rst = 1'b1;
    #1;
    model_reset();
    check_ctrl(5'b00000);
    check_regs();
    @(posedge clk);
    @(negedge clk);
    rst      = 1'b0;
    dmem_req = 1'b0;
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    check_eq("restart_timeout", 32'(mem_timeout), 32'd1);

    // Randomized traffic with occasional resets.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99) == 0) begin
        do_reset();
      end else begin
        cycle(($urandom_range(9) < 4), $urandom_range(1) == 1, ($urandom_range(4) == 0),
              ($urandom_range(9) < 4));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
